// File: rtl/fm_tx_pkg.sv
// Shared types, width helpers and saturation function for the FM transmit path.
// Used by preemphasis and sat_clamp.
package fm_tx_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int BITS_IN_DEF    = 12;
    localparam int HEADROOM_DEF   = 4;
    localparam int EMPH_SHIFT_DEF = 3;

    // first difference of two BITS_IN samples needs one extra bit
    function automatic int bits_diff(input int bi);
        return bi + 1;
    endfunction

    // sum of scaled x and scaled diff, one bit above the wider term
    function automatic int bits_sum(input int bi, input int h, input int e);
        int a;
        int b;
        a = bi + h;
        b = bi + 1 + e;
        return ((a > b) ? a : b) + 1;
    endfunction

    localparam int BITS_DIFF = bits_diff(BITS_IN_DEF);
    localparam int BITS_SUM  = bits_sum(BITS_IN_DEF, HEADROOM_DEF,
                                        EMPH_SHIFT_DEF);

    // clamp a signed value into the range of a bo-bit signed number
    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] v,
        input int                 bo
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bo - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Signed saturator from IW bits down to OW bits with overflow flag.
// IW must be below 32.
module sat_clamp
    import fm_tx_pkg::*;
#(
    parameter int IW = 17,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);

    logic signed [31:0] wide;
    logic signed [31:0] sat;

    // sign-extend, clamp, and flag whenever clamping changed the value
    always_comb begin
        wide = {{(32-IW){din[IW-1]}}, din};
        sat  = saturate(wide, OW);
        dout = OW'(sat);
        ovf  = (sat != wide);
    end

endmodule

// File: rtl/preemphasis.sv
// First-order FM pre-emphasis: y = (x <<< HEADROOM) + ((x - x_prev) <<< EMPH_SHIFT).
// Define PREEMPH_CLIP_COUNT_EN to build the saturation event counter.
module preemphasis
    import fm_tx_pkg::*;
#(
    parameter int BITS_IN    = 12,
    parameter int BITS_OUT   = 16,
    parameter int HEADROOM   = 4,
    parameter int EMPH_SHIFT = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [BITS_IN-1:0]  in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [BITS_OUT-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       bypass,
    output logic                       clip,
    input  logic                       clip_clear,
    output logic [15:0]                clip_count
);

    localparam int BD = bits_diff(BITS_IN);
    localparam int BS = bits_sum(BITS_IN, HEADROOM, EMPH_SHIFT);

    state_t                     state;
    state_t                     state_nx;
    logic signed [BITS_IN-1:0]  x_prev;
    logic signed [BD-1:0]       diff;
    logic signed [BS-1:0]       x_sc;
    logic signed [BS-1:0]       d_sc;
    logic signed [BS-1:0]       sum;
    logic signed [BITS_OUT-1:0] y_sat;
    logic                       ovf;
    logic                       accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= PRIME;
        else
            state <= state_nx;
    end

    // leave PRIME on the first accepted sample, then stay in RUN
    always_comb begin
        state_nx = state;
        if (accept && state == PRIME)
            state_nx = RUN;
    end

    // emphasis datapath; diff is zero while priming or bypassed
    always_comb begin
        diff = '0;
        if (state == RUN && !bypass)
            diff = {in_data[BITS_IN-1], in_data}
                 - {x_prev[BITS_IN-1], x_prev};
        x_sc = {{(BS-BITS_IN){in_data[BITS_IN-1]}}, in_data} <<< HEADROOM;
        d_sc = {{(BS-BD){diff[BD-1]}}, diff} <<< EMPH_SHIFT;
        sum  = x_sc + d_sc;
    end

    sat_clamp #(
        .IW (BS),
        .OW (BITS_OUT)
    ) u_sat (
        .din  (sum),
        .dout (y_sat),
        .ovf  (ovf)
    );

    // history sample follows every accept, bypass included
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            x_prev <= '0;
        else if (accept)
            x_prev <= in_data;
    end

    // registered output stage with valid/ready hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= y_sat;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // sticky clip flag; a new saturation beats clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            clip <= 1'b0;
        else if (accept && ovf)
            clip <= 1'b1;
        else if (clip_clear)
            clip <= 1'b0;
    end

`ifdef PREEMPH_CLIP_COUNT_EN
    logic [15:0] cnt;

    // saturating event counter; increment beats clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (accept && ovf) begin
            if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end else if (clip_clear)
            cnt <= '0;
    end

    assign clip_count = cnt;
`else
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_preemphasis.sv
// Self-checking bench for preemphasis: vector table plus scoreboard queue,
// with hand sequences for reset, backpressure and clip handling.
module tb_preemphasis;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic signed [11:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               bypass = 1'b0;
    logic               clip;
    logic               clip_clear = 1'b0;
    logic [15:0]        clip_count;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    typedef struct {
        int x;
        bit byp;
        int y;
    } vec_t;

    vec_t tbl[11];

    preemphasis dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bypass     (bypass),
        .clip       (clip),
        .clip_clear (clip_clear),
        .clip_count (clip_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: compare each output transfer with the oldest expectation
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", int'(out_data), 99999);
            end else begin
                chk("out_data", int'(out_data), exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic signed [11:0] x, input logic byp,
                        input int e);
        int n;
        n = 0;
        in_data  = x;
        bypass   = byp;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int cnt_exp;
`ifdef PREEMPH_CLIP_COUNT_EN
        cnt_exp = 2;
`else
        cnt_exp = 0;
`endif
        tbl[0]  = '{x:     0, byp: 1'b0, y:      0};
        tbl[1]  = '{x:   100, byp: 1'b0, y:   2400};
        tbl[2]  = '{x:   100, byp: 1'b0, y:   1600};
        tbl[3]  = '{x: -2048, byp: 1'b0, y: -32768};
        tbl[4]  = '{x:  2047, byp: 1'b0, y:  32767};
        tbl[5]  = '{x:     0, byp: 1'b1, y:      0};
        tbl[6]  = '{x:  1000, byp: 1'b1, y:  16000};
        tbl[7]  = '{x:  1000, byp: 1'b0, y:  16000};
        tbl[8]  = '{x: -1000, byp: 1'b0, y: -32000};
        tbl[9]  = '{x:     0, byp: 1'b0, y:   8000};
        tbl[10] = '{x:    -5, byp: 1'b0, y:   -120};

        repeat (3) @(negedge clock);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_clip_count", int'(clip_count), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", int'(in_ready), 1);

        send(12'sd500, 1'b0, 8000);
        chk("first_valid", int'(out_valid), 1);
        chk("first_data", int'(out_data), 8000);
        drain();

        out_ready = 1'b0;
        @(negedge clock);
        send(12'sd700, 1'b0, 12800);
        chk("held_valid", int'(out_valid), 1);
        chk("held_data", int'(out_data), 12800);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_data", int'(out_data), 0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++)
            send(12'(tbl[i].x), tbl[i].byp, tbl[i].y);
        drain();
        chk("clip_set", int'(clip), 1);
        chk("clip_count", int'(clip_count), cnt_exp);

        @(negedge clock);
        clip_clear = 1'b1;
        @(posedge clock);
        #1 clip_clear = 1'b0;
        chk("clip_cleared", int'(clip), 0);
        chk("count_cleared", int'(clip_count), 0);

        for (int i = 5; i < 11; i++)
            send(12'(tbl[i].x), tbl[i].byp, tbl[i].y);
        drain();
        chk("clip_stays_clear", int'(clip), 0);

        @(negedge clock);
        out_ready = 1'b0;
        send(12'sd300, 1'b0, 7240);
        in_data  = 12'sd400;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_data", int'(out_data), 7240);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(12'sd400, 1'b0, 7200);
        send(12'sd400, 1'b0, 6400);
        drain();

        repeat (2) @(negedge clock);
        chk("idle_valid", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
